// File: rtl/img_pkg.sv
// Shared types and constants for the image-effects filter pipeline.
// Holds the pixel type, the 3x3 window layout and the window generator states.
package img_pkg;

   typedef logic [11:0]  pixel_t;
   typedef logic [107:0] window_t;

   localparam int PIX_W = 12;

   // LSB position of each neighbour inside the packed 3x3 window
   localparam int CENTER    = 96;
   localparam int LEFT      = 84;
   localparam int RIGHT     = 72;
   localparam int UP        = 60;
   localparam int DOWN      = 48;
   localparam int UPLEFT    = 36;
   localparam int UPRIGHT   = 24;
   localparam int DOWNLEFT  = 12;
   localparam int DOWNRIGHT = 0;

   typedef enum logic [1:0] {
      WAIT_SOF = 2'd0,
      FILL     = 2'd1,
      RUN      = 2'd2,
      DRAIN    = 2'd3
   } win_state_t;

   // Places the nine neighbours at their fixed field positions
   function automatic window_t pack_window(
      input pixel_t c,
      input pixel_t l,
      input pixel_t r,
      input pixel_t u,
      input pixel_t d,
      input pixel_t ul,
      input pixel_t ur,
      input pixel_t dl,
      input pixel_t dr
   );
      window_t w;
      w = '0;
      w[CENTER    +: PIX_W] = c;
      w[LEFT      +: PIX_W] = l;
      w[RIGHT     +: PIX_W] = r;
      w[UP        +: PIX_W] = u;
      w[DOWN      +: PIX_W] = d;
      w[UPLEFT    +: PIX_W] = ul;
      w[UPRIGHT   +: PIX_W] = ur;
      w[DOWNLEFT  +: PIX_W] = dl;
      w[DOWNRIGHT +: PIX_W] = dr;
      return w;
   endfunction

endpackage

// File: rtl/line_buffer.sv
// One image row of pixels as a circular RAM: combinational read of the old
// contents at addr, registered write of the new pixel to the same slot.
module line_buffer
   import img_pkg::*;
#(
   parameter int DEPTH = 640,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  pixel_t        wdata,
   output pixel_t        rdata
);

   pixel_t mem [DEPTH];

   assign rdata = mem[addr];

   // Replace the slot just read with the pixel one row newer
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

endmodule

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator with edge replication.
// Two line buffers supply the two older rows of the incoming column; three
// row shift registers (two stored taps plus the live column) form the window
// centred W+1 pixels behind the input, and clamp muxes replicate edges.
module window_3x3_gen
   import img_pkg::*;
#(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [11:0]   pixel_in,
   input  logic          pixel_valid,
   input  logic          pixel_sof,
   output logic          pixel_ready,
   output logic [107:0]  color_data,
   output logic          window_valid,
   output logic          window_last
);

   localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam logic [XW-1:0] X_MAX = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0] Y_MAX = YW'(IMG_HEIGHT - 1);

   win_state_t state;

   logic [XW-1:0] in_x;
   logic [YW-1:0] in_y;
   logic [XW-1:0] win_x;
   logic [YW-1:0] win_y;

   pixel_t up_a, up_b, mid_a, mid_b, dn_a, dn_b;
   pixel_t up_live, mid_live;

   logic accept, frame_px, drain_step, step, emit;
   logic fill_end, last_in, win_end;
   logic at_left, at_right, at_top, at_bottom;
   logic [XW-1:0] lb_addr;

   pixel_t ru_l, ru_c, ru_r, m_l, m_c, m_r, rd_l, rd_c, rd_r;
   pixel_t u_l, u_c, u_r, d_l, d_c, d_r;
   window_t window_next;

   assign accept     = pixel_valid & pixel_ready;
   assign frame_px   = accept & (pixel_sof | (state == FILL) | (state == RUN));
   assign drain_step = (state == DRAIN);
   assign step       = frame_px | drain_step;

   assign fill_end = (in_x == XW'(1)) && (in_y == YW'(1));
   assign last_in  = (in_x == X_MAX) && (in_y == Y_MAX);
   assign win_end  = (win_x == X_MAX) && (win_y == Y_MAX);

   assign emit = drain_step
               | (frame_px & ~pixel_sof & ((state == RUN) | ((state == FILL) & fill_end)));

   assign lb_addr = (accept & pixel_sof) ? '0 : in_x;

   line_buffer #(.DEPTH(IMG_WIDTH), .AW(XW)) u_lb_prev (
      .clk   (clk),
      .we    (frame_px),
      .addr  (lb_addr),
      .wdata (pixel_in),
      .rdata (mid_live)
   );

   line_buffer #(.DEPTH(IMG_WIDTH), .AW(XW)) u_lb_prev2 (
      .clk   (clk),
      .we    (frame_px),
      .addr  (lb_addr),
      .wdata (mid_live),
      .rdata (up_live)
   );

   assign at_left   = (win_x == '0);
   assign at_right  = (win_x == X_MAX);
   assign at_top    = (win_y == '0);
   assign at_bottom = (win_y == Y_MAX);

   assign ru_l = at_left  ? up_b  : up_a;
   assign ru_c = up_b;
   assign ru_r = at_right ? up_b  : up_live;
   assign m_l  = at_left  ? mid_b : mid_a;
   assign m_c  = mid_b;
   assign m_r  = at_right ? mid_b : mid_live;
   assign rd_l = at_left  ? dn_b  : dn_a;
   assign rd_c = dn_b;
   assign rd_r = at_right ? dn_b  : pixel_in;

   assign u_l = at_top    ? m_l : ru_l;
   assign u_c = at_top    ? m_c : ru_c;
   assign u_r = at_top    ? m_r : ru_r;
   assign d_l = at_bottom ? m_l : rd_l;
   assign d_c = at_bottom ? m_c : rd_c;
   assign d_r = at_bottom ? m_r : rd_r;

   assign window_next = pack_window(m_c, m_l, m_r, u_c, d_c, u_l, u_r, d_l, d_r);

   // Shift the newest column into the row taps on every accept or drain step
   always_ff @(posedge clk) begin
      if (reset) begin
         up_a  <= '0;
         up_b  <= '0;
         mid_a <= '0;
         mid_b <= '0;
         dn_a  <= '0;
         dn_b  <= '0;
      end else if (step) begin
         up_a  <= up_b;
         up_b  <= up_live;
         mid_a <= mid_b;
         mid_b <= mid_live;
         dn_a  <= dn_b;
         dn_b  <= pixel_in;
      end
   end

   // Frame sequencing, input/window position counters and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= WAIT_SOF;
         pixel_ready  <= 1'b1;
         window_valid <= 1'b0;
         window_last  <= 1'b0;
         color_data   <= '0;
         in_x         <= '0;
         in_y         <= '0;
         win_x        <= '0;
         win_y        <= '0;
      end else begin
         window_valid <= emit;
         window_last  <= emit & win_end;

         if (emit) begin
            color_data <= window_next;
            if (win_x == X_MAX) begin
               win_x <= '0;
               win_y <= (win_y == Y_MAX) ? '0 : win_y + 1'b1;
            end else begin
               win_x <= win_x + 1'b1;
            end
         end

         if (frame_px) begin
            if (pixel_sof) begin
               in_x  <= XW'(1);
               in_y  <= '0;
               win_x <= '0;
               win_y <= '0;
            end else if (in_x == X_MAX) begin
               in_x <= '0;
               in_y <= (in_y == Y_MAX) ? '0 : in_y + 1'b1;
            end else begin
               in_x <= in_x + 1'b1;
            end
         end else if (drain_step) begin
            in_x <= (in_x == X_MAX) ? '0 : in_x + 1'b1;
         end

         case (state)
            WAIT_SOF: begin
               if (frame_px) begin
                  state <= FILL;
               end
            end
            FILL: begin
               if (frame_px && !pixel_sof && fill_end) begin
                  if (last_in) begin
                     state       <= DRAIN;
                     pixel_ready <= 1'b0;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (frame_px) begin
                  if (pixel_sof) begin
                     state <= FILL;
                  end else if (last_in) begin
                     state       <= DRAIN;
                     pixel_ready <= 1'b0;
                  end
               end
            end
            DRAIN: begin
               if (win_end) begin
                  state       <= WAIT_SOF;
                  pixel_ready <= 1'b1;
               end
            end
            default: begin
               state       <= WAIT_SOF;
               pixel_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Scoreboard bench for window_3x3_gen on a 4x3 image: a clamped-coordinate
// model predicts each window as pixels are accepted, a negedge monitor pops
// and compares every emitted window.
module tb_window_3x3_gen;

   localparam int W = 4;
   localparam int H = 3;
   localparam int N = W * H;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [11:0]  pixel_in = '0;
   logic         pixel_valid = 1'b0;
   logic         pixel_sof = 1'b0;
   logic         pixel_ready;
   logic [107:0] color_data;
   logic         window_valid;
   logic         window_last;

   typedef struct packed {
      logic [107:0] data;
      logic         last;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          total = 0;
   int          bad = 0;
   int          win_count = 0;
   logic [11:0] img [N];
   int          mj = 0;
   bit          in_frame = 1'b0;

   window_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk          (clk),
      .reset        (reset),
      .pixel_in     (pixel_in),
      .pixel_valid  (pixel_valid),
      .pixel_sof    (pixel_sof),
      .pixel_ready  (pixel_ready),
      .color_data   (color_data),
      .window_valid (window_valid),
      .window_last  (window_last)
   );

   always #5 clk = ~clk;

   // Pixel of the current model frame with coordinates clamped into the image
   function automatic logic [11:0] px(input int x, input int y);
      int xc, yc;
      xc = (x < 0) ? 0 : ((x > W - 1) ? W - 1 : x);
      yc = (y < 0) ? 0 : ((y > H - 1) ? H - 1 : y);
      return img[yc * W + xc];
   endfunction

   function automatic logic [107:0] model_win(input int c);
      int x, y;
      x = c % W;
      y = c / W;
      return {px(x, y), px(x - 1, y), px(x + 1, y), px(x, y - 1), px(x, y + 1),
              px(x - 1, y - 1), px(x + 1, y - 1), px(x - 1, y + 1), px(x + 1, y + 1)};
   endfunction

   task automatic push_win(input int c);
      exp_q.push_back('{data: model_win(c), last: (c == N - 1)});
   endtask

   // Model of one accepted pixel: frame tracking plus expected windows
   task automatic model_accept(input logic [11:0] v, input logic sof);
      if (sof) begin
         mj = 0;
         in_frame = 1'b1;
      end else if (in_frame) begin
         mj++;
      end else begin
         return;
      end
      img[mj] = v;
      if (mj >= W + 1) push_win(mj - W - 1);
      if (mj == N - 1) begin
         for (int c = N - W - 1; c < N; c++) push_win(c);
         in_frame = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      if (!reset && window_valid) begin
         win_count++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL window_extra: got %h last=%b, no window expected", color_data, window_last);
         end else begin
            mon_e = exp_q.pop_front();
            if (color_data !== mon_e.data || window_last !== mon_e.last) begin
               bad++;
               $display("[TB] FAIL window_data: got %h last=%b, expected %h last=%b",
                        color_data, window_last, mon_e.data, mon_e.last);
            end
         end
      end
   end

   task automatic send_pixel(input logic [11:0] v, input logic sof);
      int guard;
      guard = 0;
      pixel_in = v;
      pixel_sof = sof;
      pixel_valid = 1'b1;
      while (pixel_ready !== 1'b1 && guard < 50) begin
         @(posedge clk);
         #1;
         guard++;
      end
      total++;
      if (pixel_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL ready_timeout: pixel_ready=%b, expected 1", pixel_ready);
      end
      @(posedge clk);
      model_accept(v, sof);
      #1;
   endtask

   task automatic idle_check(input int k);
      pixel_valid = 1'b0;
      pixel_sof = 1'b0;
      repeat (k) begin
         @(posedge clk);
         @(negedge clk);
         total++;
         if (window_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL gap_window: window_valid=%b, expected 0", window_valid);
         end
      end
   endtask

   task automatic wait_drain();
      int guard;
      guard = 0;
      pixel_valid = 1'b0;
      pixel_sof = 1'b0;
      while ((exp_q.size() != 0 || pixel_ready !== 1'b1) && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      total++;
      if (exp_q.size() != 0 || pixel_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL drain_timeout: pending=%0d ready=%b, expected 0 and 1", exp_q.size(), pixel_ready);
      end
   endtask

   task automatic check_count(input string name, input int got, input int want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s: got %0d windows, expected %0d", name, got, want);
      end
   endtask

   task automatic send_frame(input logic [11:0] base, input bit gaps);
      for (int j = 0; j < N; j++) begin
         if (gaps) idle_check($urandom_range(0, 2));
         send_pixel(base + 12'(j), j == 0);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total += 4;
      if (pixel_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %b, expected 1", pixel_ready); end
      if (window_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b, expected 0", window_valid); end
      if (window_last !== 1'b0) begin bad++; $display("[TB] FAIL reset_last: got %b, expected 0", window_last); end
      if (color_data !== 108'h0) begin bad++; $display("[TB] FAIL reset_data: got %h, expected 0", color_data); end
      reset = 1'b0;
   endtask

   task automatic test_basic_frame();
      int lowcnt, wc0;
      bit got_last;
      logic [107:0] last_data;
      logic exp_valid;
      wc0 = win_count;
      got_last = 1'b0;
      last_data = '0;
      for (int j = 0; j < N; j++) begin
         send_pixel(12'(j), j == 0);
         @(negedge clk);
         exp_valid = (j >= W + 1);
         total++;
         if (window_valid !== exp_valid) begin
            bad++;
            $display("[TB] FAIL valid_timing: after pixel %0d window_valid=%b, expected %b", j, window_valid, exp_valid);
         end
         if (j == W + 1) begin
            total++;
            if (color_data !== 108'h000_000_001_000_004_000_001_004_005) begin
               bad++;
               $display("[TB] FAIL window_00: got %h, expected 000000001000004000001004005", color_data);
            end
         end
      end
      pixel_valid = 1'b0;
      lowcnt = (pixel_ready === 1'b0) ? 1 : 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (pixel_ready === 1'b0) lowcnt++;
         if (window_valid === 1'b1 && window_last === 1'b1) begin
            got_last = 1'b1;
            last_data = color_data;
         end
      end
      total += 2;
      if (lowcnt !== W + 1) begin
         bad++;
         $display("[TB] FAIL drain_ready: ready low %0d cycles, expected %0d", lowcnt, W + 1);
      end
      if (!got_last || last_data !== 108'h00B_00A_00B_007_00B_006_007_00A_00B) begin
         bad++;
         $display("[TB] FAIL window_32: seen=%0b got %h, expected 00B00A00B00700B00600700A00B", got_last, last_data);
      end
      wait_drain();
      check_count("basic_count", win_count - wc0, N);
   endtask

   task automatic test_gaps();
      int wc0;
      wc0 = win_count;
      send_frame(12'h000, 1'b1);
      wait_drain();
      check_count("gap_count", win_count - wc0, N);
   endtask

   task automatic test_no_sof();
      int wc0;
      wc0 = win_count;
      for (int k = 0; k < 5; k++) send_pixel(12'h0F0 + 12'(k), 1'b0);
      idle_check(2);
      send_frame(12'h000, 1'b0);
      wait_drain();
      check_count("nosof_count", win_count - wc0, N);
   endtask

   task automatic test_abort();
      int wc0;
      wc0 = win_count;
      for (int j = 0; j < 7; j++) send_pixel(12'h100 + 12'(j), j == 0);
      send_pixel(12'h200, 1'b1);
      @(negedge clk);
      total += 2;
      if (pixel_ready !== 1'b1) begin bad++; $display("[TB] FAIL abort_ready: got %b, expected 1", pixel_ready); end
      if (window_valid !== 1'b0) begin bad++; $display("[TB] FAIL abort_window: got %b, expected 0", window_valid); end
      for (int j = 1; j < N; j++) begin
         send_pixel(12'h200 + 12'(j), 1'b0);
         if (j == W + 1) begin
            @(negedge clk);
            total++;
            if (color_data !== 108'h200_200_201_200_204_200_201_204_205) begin
               bad++;
               $display("[TB] FAIL abort_window_00: got %h, expected 200200201200204200201204205", color_data);
            end
         end
      end
      wait_drain();
      check_count("abort_count", win_count - wc0, 2 + N);
   endtask

   task automatic test_reset_in_drain();
      int wc0;
      send_frame(12'h300, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      pixel_valid = 1'b0;
      pixel_sof = 1'b0;
      @(posedge clk);
      @(negedge clk);
      total += 3;
      if (window_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_drain_valid: got %b, expected 0", window_valid); end
      if (pixel_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_drain_ready: got %b, expected 1", pixel_ready); end
      if (color_data !== 108'h0) begin bad++; $display("[TB] FAIL rst_drain_data: got %h, expected 0", color_data); end
      reset = 1'b0;
      exp_q.delete();
      in_frame = 1'b0;
      mj = 0;
      wc0 = win_count;
      for (int k = 0; k < 3; k++) send_pixel(12'h3A0 + 12'(k), 1'b0);
      idle_check(2);
      send_frame(12'h400, 1'b0);
      wait_drain();
      check_count("post_reset_count", win_count - wc0, N);
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_gaps();
      test_no_sof();
      test_abort();
      test_reset_in_drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running, bad=%0d", bad);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
